// File: rtl/uart_periph_pkg.sv
// UART peripheral shared definitions: register map, status bit positions, FSM state types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_periph_pkg;

  localparam logic [1:0] UART_ADDR_RXDATA = 2'b00;
  localparam logic [1:0] UART_ADDR_STATUS = 2'b01;
  localparam logic [1:0] UART_ADDR_TXDATA = 2'b10;
  localparam logic [1:0] UART_ADDR_CTRL   = 2'b11;

  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_READY   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;

  // 50 MHz core clock at 115200 baud
  localparam int UART_CLK_DIV = 434;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received characters; head is visible on dout (show-ahead).
// Latency: a push is visible on dout/count the cycle after the pushing edge.
// Backpressure: push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_periph.sv
// Bus-slave UART: 8N1 transmitter from TXDATA writes, receiver into an RX FIFO, status/ctrl registers.
// Latency: uart_dout valid the cycle after uart_rd; TX frame starts the edge after an accepted write.
// Backpressure: TXDATA writes while busy are dropped (poll tx_ready); RX bytes arriving at a full FIFO set rx_overrun.
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rd,
  input  logic              uart_wr,
  input  logic [1:0]        uart_addr,
  input  logic [DATA_W-1:0] uart_din,
  output logic [DATA_W-1:0] uart_dout,
  input  logic              rxd,
  output logic              txd
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_W - 1);

  tx_state_t         tx_state;
  logic [CNT_W-1:0]  tx_cnt;
  logic [2:0]        tx_bit;
  logic [DATA_W-1:0] tx_shift;

  rx_state_t         rx_state;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_prev;
  logic              rx_push;
  logic              rx_ferr;

  logic              rxd_s1;
  logic              rxd_s2;
  logic              rx_in;

  logic              ctrl_loop;
  logic              rx_overrun;
  logic              frame_err;

  logic [DATA_W-1:0]           fifo_dout;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_pop;

  logic              tx_ready;
  logic              wr_tx;
  logic              wr_ctrl;
  logic              rd_status;
  logic              overrun_set;
  logic [DATA_W-1:0] status_word;

  assign tx_ready    = (tx_state == TX_IDLE);
  assign wr_tx       = uart_wr && (uart_addr == UART_ADDR_TXDATA) && tx_ready;
  assign wr_ctrl     = uart_wr && (uart_addr == UART_ADDR_CTRL);
  assign rd_status   = uart_rd && (uart_addr == UART_ADDR_STATUS);
  assign fifo_pop    = uart_rd && (uart_addr == UART_ADDR_RXDATA) && !fifo_empty;
  assign overrun_set = rx_push && fifo_full && !fifo_pop;
  assign rx_in       = ctrl_loop ? txd : rxd_s2;

  // Status register image as seen by a read this cycle
  always_comb begin
    status_word                = '0;
    status_word[ST_RX_AVAIL]   = (fifo_count != '0);
    status_word[ST_TX_READY]   = tx_ready;
    status_word[ST_RX_OVERRUN] = rx_overrun;
    status_word[ST_FRAME_ERR]  = frame_err;
  end

  // TX serialiser: start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr_tx) begin
            tx_state <= TX_START;
            tx_shift <= uart_din;
            tx_cnt   <= '0;
            txd      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
              txd      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous serial input; idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // RX deserialiser: mid-bit sampling, glitch rejection on start, push/frame-error pulse at mid-stop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_prev  <= 1'b1;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_prev <= rx_in;
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_in) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_in ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_in, rx_shift[DATA_W-1:1]};
            if (rx_bit == BIT_LAST) rx_state <= RX_STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            rx_push  <= rx_in;
            rx_ferr  <= !rx_in;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (rx_shift),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky flags (set beats read-clear) and the loopback control bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      ctrl_loop  <= 1'b0;
    end else begin
      if (overrun_set)    rx_overrun <= 1'b1;
      else if (rd_status) rx_overrun <= 1'b0;
      if (rx_ferr)        frame_err  <= 1'b1;
      else if (rd_status) frame_err  <= 1'b0;
      if (wr_ctrl)        ctrl_loop  <= uart_din[0];
    end
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_dout <= '0;
    end else if (uart_rd) begin
      case (uart_addr)
        UART_ADDR_RXDATA: uart_dout <= fifo_empty ? '0 : fifo_dout;
        UART_ADDR_STATUS: uart_dout <= status_word;
        UART_ADDR_CTRL:   uart_dout <= DATA_W'(ctrl_loop);
        default:          uart_dout <= '0;
      endcase
    end
  end

endmodule
